// File: rtl/strm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : strm_pkg
//  Description : Shared constants, default AXI widths, AR descriptor type and
//                helpers for the streaming-engine AXI read arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
package strm_pkg;

    // AXI size encoding for 64-byte beats
    localparam logic [2:0] STRM_ARSIZE_64B = 3'b110;

    // Default AXI widths of the virtual memory interface
    localparam int STRM_ADDR_W = 64;
    localparam int STRM_DATA_W = 512;
    localparam int STRM_ID_W   = 16;

    // One AR descriptor as carried by the default-width channel
    typedef struct packed {
        logic [STRM_ADDR_W-1:0] addr;
        logic [7:0]             len;
        logic [STRM_ID_W-1:0]   id;
    } strm_ar_t;

    // Width of a binary requester index for n requesters (n >= 2)
    function automatic int idx_w(input int n);
        return $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/strm_ar_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : strm_ar_arbiter_if
//  Description : Bundle of the requester-side AR/R handshakes and the shared
//                AXI read channel towards axi_m.
//                master : arbiter view (drives m_ar*, m_rready, req_arready,
//                         req_r*)
//                slave  : environment view (engines + axi_m)
//  Revision    : 1.0  initial release
// ============================================================================
interface strm_ar_arbiter_if
    import strm_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = STRM_ADDR_W,
    parameter int DATA_W  = STRM_DATA_W,
    parameter int ID_W    = STRM_ID_W
);
    // requester AR side
    logic [NUM_REQ-1:0]        req_arvalid;
    logic [NUM_REQ*ADDR_W-1:0] req_araddr;
    logic [NUM_REQ*8-1:0]      req_arlen;
    logic [NUM_REQ-1:0]        req_arready;
    // shared AR channel
    logic [ID_W-1:0]           m_arid;
    logic [ADDR_W-1:0]         m_araddr;
    logic [7:0]                m_arlen;
    logic [2:0]                m_arsize;
    logic                      m_arvalid;
    logic                      m_arready;
    // shared R channel
    logic [ID_W-1:0]           m_rid;
    logic [DATA_W-1:0]         m_rdata;
    logic                      m_rlast;
    logic                      m_rvalid;
    logic                      m_rready;
    // requester R side
    logic [NUM_REQ-1:0]        req_rvalid;
    logic [DATA_W-1:0]         req_rdata;
    logic                      req_rlast;
    logic [NUM_REQ-1:0]        req_rready;

    modport master (
        input  req_arvalid, req_araddr, req_arlen, m_arready,
               m_rid, m_rdata, m_rlast, m_rvalid, req_rready,
        output req_arready, m_arid, m_araddr, m_arlen, m_arsize, m_arvalid,
               m_rready, req_rvalid, req_rdata, req_rlast
    );

    modport slave (
        output req_arvalid, req_araddr, req_arlen, m_arready,
               m_rid, m_rdata, m_rlast, m_rvalid, req_rready,
        input  req_arready, m_arid, m_araddr, m_arlen, m_arsize, m_arvalid,
               m_rready, req_rvalid, req_rdata, req_rlast
    );

endinterface
`default_nettype wire

// File: rtl/strm_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : strm_rr_pick
//  Description : Combinational round-robin picker. Selects the first eligible
//                index at or after ptr, wrapping at N.
//  Ports       : eligible [N]     request mask
//                ptr      [IDX_W] search start index (< N)
//                grant    [N]     one-hot winner
//                idx      [IDX_W] binary winner
//                any      [1]     at least one eligible
//  Revision    : 1.0  initial release
// ============================================================================
module strm_rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     eligible,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [IDX_W-1:0] w_j;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        w_j   = '0;
        for (int k = 0; k < N; k++) begin
            w_j = IDX_W'((32'(ptr) + k) % N);
            if (!any && eligible[w_j]) begin
                any        = 1'b1;
                idx        = w_j;
                grant[w_j] = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/strm_ar_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : strm_ar_arbiter
//  Description : Shares one AXI read channel (AR + R) among NUM_REQ streaming
//                engines. Round-robin AR arbitration with per-requester
//                outstanding-burst cap; arid carries the requester index and
//                R beats are routed back by rid.
//  Ports       : clk, rst    clock, synchronous active-high reset
//                bus         requester + axi_m read handshakes (master view)
//                outst_cnt   per-requester outstanding bursts, 8 bits each
//                err_rid     sticky: unknown rid, or rlast at count 0
//  Revision    : 1.0  initial release
// ============================================================================
module strm_ar_arbiter
    import strm_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int ADDR_W    = STRM_ADDR_W,
    parameter int DATA_W    = STRM_DATA_W,
    parameter int ID_W      = STRM_ID_W,
    parameter int MAX_OUTST = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    strm_ar_arbiter_if.master    bus,
    output logic [NUM_REQ*8-1:0] outst_cnt,
    output logic                 err_rid
);

    localparam int IDX_W = idx_w(NUM_REQ);

    logic [7:0]         r_cnt [NUM_REQ];
    logic               r_arvalid;
    logic [ID_W-1:0]    r_arid;
    logic [ADDR_W-1:0]  r_araddr;
    logic [7:0]         r_arlen;
    logic [IDX_W-1:0]   r_ptr;
    logic               r_err;

    logic [NUM_REQ-1:0] w_elig;
    logic [NUM_REQ-1:0] w_grant;
    logic [IDX_W-1:0]   w_win;
    logic               w_any;
    logic               w_load;
    logic [ADDR_W-1:0]  w_sel_addr;
    logic [7:0]         w_sel_len;

    logic [IDX_W-1:0]   w_ridx;
    logic               w_rid_hi_zero;
    logic               w_rid_ok;
    logic               w_rcnt_zero;
    logic [NUM_REQ-1:0] w_rvalid;
    logic               w_rready;
    logic               w_rdone;
    logic [NUM_REQ-1:0] w_inc;
    logic [NUM_REQ-1:0] w_dec;

    // ---------------------------------------------------------------- AR side
    always_comb begin
        w_elig = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_elig[i] = bus.req_arvalid[i] && (r_cnt[i] != 8'(MAX_OUTST));
        end
    end

    strm_rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .eligible (w_elig),
        .ptr      (r_ptr),
        .grant    (w_grant),
        .idx      (w_win),
        .any      (w_any)
    );

    // The output register may only be overwritten when empty or draining
    assign w_load = (!r_arvalid || bus.m_arready) && w_any;

    always_comb begin
        w_sel_addr = '0;
        w_sel_len  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_sel_addr = bus.req_araddr[i*ADDR_W +: ADDR_W];
                w_sel_len  = bus.req_arlen[i*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_arvalid <= 1'b0;
            r_arid    <= '0;
            r_araddr  <= '0;
            r_arlen   <= '0;
            r_ptr     <= '0;
        end else if (w_load) begin
            r_arvalid <= 1'b1;
            r_arid    <= {{(ID_W-IDX_W){1'b0}}, w_win};
            r_araddr  <= w_sel_addr;
            r_arlen   <= w_sel_len;
            r_ptr     <= (w_win == IDX_W'(NUM_REQ-1)) ? '0 : w_win + IDX_W'(1);
        end else if (bus.m_arready) begin
            r_arvalid <= 1'b0;
        end
    end

    assign bus.req_arready = w_load ? w_grant : '0;
    assign bus.m_arvalid   = r_arvalid;
    assign bus.m_arid      = r_arid;
    assign bus.m_araddr    = r_araddr;
    assign bus.m_arlen     = r_arlen;
    assign bus.m_arsize    = STRM_ARSIZE_64B;

    // ----------------------------------------------------------------- R side
    // Beats with an out-of-range index or non-zero upper id bits belong to no
    // requester; they are accepted and dropped so the channel never stalls.
    always_comb begin
        w_rid_hi_zero = ((bus.m_rid >> IDX_W) == '0);
        w_ridx        = bus.m_rid[IDX_W-1:0];
        w_rid_ok      = 1'b0;
        w_rvalid      = '0;
        w_rready      = 1'b1;
        w_rcnt_zero   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_rid_hi_zero && (w_ridx == IDX_W'(i))) begin
                w_rid_ok    = 1'b1;
                w_rvalid[i] = bus.m_rvalid;
                w_rready    = bus.req_rready[i];
                w_rcnt_zero = (r_cnt[i] == 8'd0);
            end
        end
    end

    assign w_rdone        = bus.m_rvalid && w_rready && bus.m_rlast && w_rid_ok;
    assign bus.req_rvalid = w_rvalid;
    assign bus.m_rready   = w_rready;
    assign bus.req_rdata  = bus.m_rdata[DATA_W-1:0];
    assign bus.req_rlast  = bus.m_rlast;

    // ------------------------------------------------------ outstanding count
    always_comb begin
        w_inc = '0;
        w_dec = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_inc[i] = w_load && w_grant[i];
            w_dec[i] = w_rdone && (w_ridx == IDX_W'(i));
        end
    end

    // Simultaneous grant and completion cancel; a completion at 0 is stale
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (w_inc[i] && !w_dec[i]) begin
                    r_cnt[i] <= r_cnt[i] + 8'd1;
                end else if (w_dec[i] && !w_inc[i] && (r_cnt[i] != 8'd0)) begin
                    r_cnt[i] <= r_cnt[i] - 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if ((bus.m_rvalid && !w_rid_ok) || (w_rdone && w_rcnt_zero)) begin
            r_err <= 1'b1;
        end
    end

    assign err_rid = r_err;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cnt_out
            assign outst_cnt[gi*8 +: 8] = r_cnt[gi];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_strm_ar_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_strm_ar_arbiter
//  Description : Directed self-checking bench for strm_ar_arbiter. A main
//                instance (MAX_OUTST=16) covers grant, round-robin,
//                backpressure, routing and reset; a second instance with
//                MAX_OUTST=2 covers the outstanding-burst cap.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_strm_ar_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] cnt;
    logic        err;
    logic [31:0] lcnt;
    logic        lerr;
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    strm_ar_arbiter_if #(.NUM_REQ(4), .ADDR_W(64), .DATA_W(512), .ID_W(16)) bus ();
    strm_ar_arbiter_if #(.NUM_REQ(4), .ADDR_W(64), .DATA_W(512), .ID_W(16)) lbus ();

    strm_ar_arbiter #(
        .NUM_REQ(4), .ADDR_W(64), .DATA_W(512), .ID_W(16), .MAX_OUTST(16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .outst_cnt (cnt),
        .err_rid   (err)
    );

    strm_ar_arbiter #(
        .NUM_REQ(4), .ADDR_W(64), .DATA_W(512), .ID_W(16), .MAX_OUTST(2)
    ) dut_lim (
        .clk       (clk),
        .rst       (rst),
        .bus       (lbus),
        .outst_cnt (lcnt),
        .err_rid   (lerr)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.req_arvalid = '0;  bus.req_araddr = '0; bus.req_arlen = '0;
        bus.m_arready   = 1'b0; bus.m_rid = '0; bus.m_rdata = '0;
        bus.m_rlast     = 1'b0; bus.m_rvalid = 1'b0; bus.req_rready = '0;
        lbus.req_arvalid = '0;  lbus.req_araddr = '0; lbus.req_arlen = '0;
        lbus.m_arready   = 1'b0; lbus.m_rid = '0; lbus.m_rdata = '0;
        lbus.m_rlast     = 1'b0; lbus.m_rvalid = 1'b0; lbus.req_rready = '0;
        cyc();
        cyc();

        // ---- reset state
        chk("rst_arvalid", bus.m_arvalid, 0);
        chk("rst_arid",    bus.m_arid, 0);
        chk("rst_araddr",  bus.m_araddr, 0);
        chk("rst_arlen",   bus.m_arlen, 0);
        chk("rst_arready", bus.req_arready, 0);
        chk("rst_cnt",     cnt, 0);
        chk("rst_err",     err, 0);
        chk("arsize",      bus.m_arsize, 3'b110);
        rst = 1'b0;

        // ---- single requester
        bus.req_arvalid = 4'b0010;
        bus.req_araddr[64 +: 64] = 64'h1000;
        bus.req_arlen[8 +: 8] = 8'd3;
        bus.m_arready = 1'b1;
        #1;
        chk("t1_arready", bus.req_arready, 4'b0010);
        chk("t1_arvalid_pre", bus.m_arvalid, 0);
        cyc();
        bus.req_arvalid = '0;
        chk("t1_arvalid", bus.m_arvalid, 1);
        chk("t1_arid",    bus.m_arid, 1);
        chk("t1_araddr",  bus.m_araddr, 64'h1000);
        chk("t1_arlen",   bus.m_arlen, 3);
        chk("t1_cnt",     cnt, 32'h0000_0100);
        cyc();
        chk("t1_arvalid_drop", bus.m_arvalid, 0);
        bus.m_rvalid = 1'b1; bus.m_rid = 16'd1; bus.req_rready = 4'b0010;
        bus.m_rdata = {8{64'hA5A5_0000_1234_5678}};
        for (int b = 0; b < 4; b++) begin
            bus.m_rlast = (b == 3);
            #1;
            chk("t1_rvalid", bus.req_rvalid, 4'b0010);
            chk("t1_rready", bus.m_rready, 1);
            chk("t1_cnt_mid", cnt, 32'h0000_0100);
            cyc();
        end
        chk("t1_rdata", bus.req_rdata[63:0], 64'hA5A5_0000_1234_5678);
        bus.m_rvalid = 1'b0; bus.m_rlast = 1'b0; bus.req_rready = '0;
        chk("t1_cnt_done", cnt, 0);
        chk("t1_err", err, 0);

        // ---- round robin, all requesters valid
        rst = 1'b1; cyc(); rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.req_araddr[i*64 +: 64] = 64'h100 * (i + 1);
            bus.req_arlen[i*8 +: 8]    = 8'(i);
        end
        bus.req_arvalid = 4'hF;
        bus.m_arready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("rr_arready", bus.req_arready, 64'(1 << (k % 4)));
            cyc();
            chk("rr_arid",   bus.m_arid, 64'(k % 4));
            chk("rr_araddr", bus.m_araddr, 64'h100 * ((k % 4) + 1));
        end
        chk("rr_cnt", cnt, 32'h0202_0202);

        // ---- backpressure: register holds arid 3, next winner is 0
        bus.m_arready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("bp_arready", bus.req_arready, 0);
            cyc();
            chk("bp_arvalid", bus.m_arvalid, 1);
            chk("bp_arid",    bus.m_arid, 3);
            chk("bp_araddr",  bus.m_araddr, 64'h400);
            chk("bp_arlen",   bus.m_arlen, 3);
        end
        bus.m_arready = 1'b1;
        #1;
        chk("bp_resume_arready", bus.req_arready, 4'b0001);
        cyc();
        chk("bp_resume_arid",   bus.m_arid, 0);
        chk("bp_resume_araddr", bus.m_araddr, 64'h100);
        bus.req_arvalid = '0;
        cyc();
        chk("bp_drain", bus.m_arvalid, 0);
        chk("bp_cnt",   cnt, 32'h0202_0203);

        // ---- R routing
        bus.m_rvalid = 1'b1; bus.m_rid = 16'd2; bus.m_rlast = 1'b0;
        bus.req_rready = 4'b1011;
        #1;
        chk("rt_rvalid", bus.req_rvalid, 4'b0100);
        chk("rt_rready", bus.m_rready, 0);
        bus.m_rid = 16'd7;
        #1;
        chk("rt_bad_rvalid", bus.req_rvalid, 0);
        chk("rt_bad_rready", bus.m_rready, 1);
        chk("rt_err_pre", err, 0);
        cyc();
        chk("rt_err_set", err, 1);
        bus.m_rid = 16'h0101; bus.req_rready = '0;
        #1;
        chk("rt_hi_rvalid", bus.req_rvalid, 0);
        chk("rt_hi_rready", bus.m_rready, 1);
        bus.m_rvalid = 1'b0; bus.m_rid = '0;
        cyc();
        chk("rt_err_sticky", err, 1);
        chk("rt_cnt", cnt, 32'h0202_0203);

        // ---- reset with three bursts outstanding on req1
        rst = 1'b1; cyc(); rst = 1'b0;
        chk("rs_err_clr", err, 0);
        chk("rs_cnt_clr", cnt, 0);
        bus.req_arvalid = 4'b0010;
        cyc(); cyc(); cyc();
        bus.req_arvalid = '0;
        chk("rs_cnt3", cnt, 32'h0000_0300);
        chk("rs_arvalid", bus.m_arvalid, 1);
        rst = 1'b1; cyc(); rst = 1'b0;
        chk("rs_cnt0", cnt, 0);
        chk("rs_arvalid0", bus.m_arvalid, 0);
        chk("rs_err0", err, 0);
        bus.m_rvalid = 1'b1; bus.m_rlast = 1'b1; bus.m_rid = 16'd1;
        bus.req_rready = 4'b0010;
        #1;
        chk("rs_rready", bus.m_rready, 1);
        cyc();
        bus.m_rvalid = 1'b0; bus.m_rlast = 1'b0; bus.req_rready = '0;
        chk("rs_stale_cnt", cnt, 0);
        chk("rs_stale_err", err, 1);

        // ---- outstanding cap (MAX_OUTST = 2)
        rst = 1'b1; cyc(); rst = 1'b0;
        lbus.req_arvalid = 4'b0001;
        lbus.req_araddr[0 +: 64] = 64'hBEEF;
        lbus.m_arready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("lim_arready", lbus.req_arready, (k < 2) ? 64'd1 : 64'd0);
            cyc();
        end
        chk("lim_cnt_full", lcnt, 2);
        lbus.m_rvalid = 1'b1; lbus.m_rlast = 1'b1; lbus.m_rid = '0;
        lbus.req_rready = 4'b0001;
        #1;
        chk("lim_full_arready", lbus.req_arready, 0);
        cyc();
        chk("lim_cnt_ret", lcnt, 1);
        #1;
        chk("lim_both_arready", lbus.req_arready, 1);
        cyc();
        chk("lim_cnt_both", lcnt, 1);
        lbus.m_rvalid = 1'b0; lbus.m_rlast = 1'b0;
        #1;
        chk("lim_regrant", lbus.req_arready, 1);
        cyc();
        chk("lim_cnt_refull", lcnt, 2);
        #1;
        chk("lim_blocked", lbus.req_arready, 0);
        chk("lim_err", lerr, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
